// File: rtl/vga_capture.sv
// vga_capture: recovers VGA line/frame timing from hsync/vsync, checks it,
// and delivers active grayscale pixels with coordinates once locked.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] pixel_in,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       line_done,
  output logic       locked,
  output logic       timing_err
);

  localparam logic [9:0] HA_LO  = 10'(H_BACK - 1);
  localparam logic [9:0] HA_HI  = 10'(H_BACK + H_ACTIVE - 2);
  localparam logic [9:0] VA_LO  = 10'(V_BACK);
  localparam logic [9:0] VA_HI  = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LEN  = 10'(V_TOTAL);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] SAT    = 10'h3ff;

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    LOCKED
  } state_t;

  state_t     state_q;
  logic       hs1_q, vs1_q, hs2_q, vs2_q;
  logic [7:0] px1_q;
  logic [9:0] h_cnt_q, v_cnt_q;
  logic [9:0] h_cnt_d, v_cnt_d;
  logic       skip_q;
  logic       pix_valid_q, frame_start_q, line_done_q;
  logic       locked_q, timing_err_q;
  logic [7:0] pix_data_q;
  logic [9:0] pix_x_q, pix_y_q;

  logic       hs_rise, vs_rise, active, run;
  logic       h_bad, v_bad, fail;
  logic [9:0] px, py, lines;

  always_comb begin
    hs_rise = hs1_q & ~hs2_q;
    vs_rise = vs1_q & ~vs2_q;
    active  = (h_cnt_q >= HA_LO) && (h_cnt_q <= HA_HI) &&
              (v_cnt_q >= VA_LO) && (v_cnt_q <= VA_HI);
    px      = h_cnt_q - HA_LO;
    py      = v_cnt_q - VA_LO;
    // a line start coincident with vsync still belongs to the old frame
    lines   = (vs_rise && hs_rise) ? v_cnt_q + 10'd1 : v_cnt_q;
    run     = state_q != IDLE;
    h_bad   = run && hs_rise && !skip_q && (h_cnt_q != H_LAST);
    v_bad   = run && vs_rise && (lines != V_LEN);
    fail    = h_bad | v_bad;
    h_cnt_d = hs_rise ? 10'd0 :
              (h_cnt_q == SAT) ? h_cnt_q : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (vs_rise)
      v_cnt_d = 10'd0;
    else if (hs_rise && v_cnt_q != SAT)
      v_cnt_d = v_cnt_q + 10'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      px1_q         <= 8'd0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      skip_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      pix_data_q    <= 8'd0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
    end else begin
      hs1_q        <= hsync_in;
      vs1_q        <= vsync_in;
      hs2_q        <= hs1_q;
      vs2_q        <= vs1_q;
      px1_q        <= pixel_in;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      timing_err_q <= fail;
      if (fail) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (vs_rise) begin
            state_q <= TRAIN;
            skip_q  <= 1'b1;
          end
          TRAIN: begin
            if (hs_rise) skip_q <= 1'b0;
            if (vs_rise) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: if (hs_rise) skip_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      if (state_q == LOCKED && !fail && active) begin
        pix_valid_q   <= 1'b1;
        pix_data_q    <= px1_q;
        pix_x_q       <= px;
        pix_y_q       <= py;
        frame_start_q <= (px == 10'd0) && (py == 10'd0);
        line_done_q   <= px == X_LAST;
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign line_done   = line_done_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scaled-down VGA source with lock, error, reset and
// coincident-sync scenarios; pixels scoreboarded with exact latency.
module tb_vga_capture;

  localparam int HA = 8;
  localparam int HB = 3;
  localparam int HT = 16;
  localparam int VA = 4;
  localparam int VB = 2;
  localparam int VT = 10;
  localparam int NF = 17;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [7:0] pixel_in = 8'd0;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [9:0] pix_x, pix_y;
  logic       frame_start, line_done, locked, timing_err;

  vga_capture #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .clock(clock), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_done(line_done),
    .locked(locked), .timing_err(timing_err)
  );

  always #20 clock = ~clock;

  typedef struct {
    int          due;
    logic [27:0] v;
  } item_t;

  typedef struct {
    int coin;
    int sline;
    int sframe;
    int rlc;
    int rhc;
    int ls;
    int le;
    int errs;
  } fr_t;

  item_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nerr, npix, npush;
  logic [27:0] last = '0;
  logic        rst_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [39:0] got,
                          input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic rst,
                      input logic [7:0] px, input logic push,
                      input logic [27:0] ev);
    logic       expv;
    logic [9:0] ex, ey;
    @(negedge clock);
    if (!rst_prev)
      check_eq("rst_zero", 40'({pix_valid, frame_start, line_done, locked,
               timing_err, pix_data, pix_x, pix_y}), 40'd0);
    expv = q.size() > 0 && q[0].due == cyc;
    if (pix_valid || expv) begin
      check_eq("valid", 40'(pix_valid), 40'(expv));
      if (expv) begin
        ex = q[0].v[27:18];
        ey = q[0].v[17:8];
        check_eq("pixel",
          40'({frame_start, line_done, pix_x, pix_y, pix_data}),
          40'({ex == 10'd0 && ey == 10'd0, ex == 10'(HA - 1), q[0].v}));
        last = q[0].v;
        void'(q.pop_front());
      end
    end else begin
      check_eq("hold", 40'({frame_start, line_done, pix_x, pix_y, pix_data}),
               40'({2'b00, last}));
    end
    if (pix_valid) npix++;
    if (timing_err) nerr++;
    hsync_in = hs;
    vsync_in = vs;
    reset    = rst;
    pixel_in = px;
    if (!rst) begin
      npush -= q.size();
      q.delete();
      last = '0;
    end
    if (push) q.push_back('{cyc + 2, ev});
    rst_prev = rst;
    cyc++;
  endtask

  initial begin
    fr_t        ft [NF];
    int         nl, ll;
    logic       hs, vs, rst, act, push, kill;
    logic [7:0] px;
    logic [9:0] x, y;
    ft[0]  = '{0, -1, 0, -1, -1, 0, 0, 0};
    ft[1]  = '{0, -1, 0, -1, -1, 1, 1, 0};
    ft[2]  = '{0, -1, 0, -1, -1, 1, 1, 0};
    ft[3]  = '{0,  3, 0, -1, -1, 1, 0, 1};
    ft[4]  = '{0, -1, 0, -1, -1, 0, 0, 0};
    ft[5]  = '{0, -1, 0, -1, -1, 1, 1, 0};
    ft[6]  = '{0, -1, 1, -1, -1, 1, 1, 0};
    ft[7]  = '{0, -1, 0, -1, -1, 0, 0, 1};
    ft[8]  = '{0, -1, 0, -1, -1, 0, 0, 0};
    ft[9]  = '{0, -1, 0, -1, -1, 1, 1, 0};
    ft[10] = '{0, -1, 0,  4,  7, 1, 0, 0};
    ft[11] = '{0, -1, 0, -1, -1, 0, 0, 0};
    ft[12] = '{0, -1, 0, -1, -1, 1, 1, 0};
    ft[13] = '{1, -1, 0, -1, -1, 1, 1, 0};
    ft[14] = '{1, -1, 0,  6,  0, 1, 0, 0};
    ft[15] = '{1, -1, 0, -1, -1, 0, 0, 0};
    ft[16] = '{1, -1, 0, -1, -1, 1, 1, 0};
    npush = 0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 28'd0);
    for (int f = 0; f < NF; f++) begin
      nl    = ft[f].sframe != 0 ? VT - 1 : VT;
      kill  = 1'b0;
      nerr  = 0;
      npix  = 0;
      npush = 0;
      for (int lc = 0; lc < nl; lc++) begin
        ll = lc == ft[f].sline ? HT - 1 : HT;
        if (ft[f].sline >= 0 && lc > ft[f].sline) kill = 1'b1;
        for (int hc = 0; hc < ll; hc++) begin
          hs  = hc < ll - 2;
          vs  = !((ft[f].coin == 0 && lc == 0 && hc < 5) ||
                  (f + 1 < NF && ft[(f + 1) % NF].coin != 0 &&
                   lc == nl - 1 && hc >= ll - 2));
          rst = !(lc == ft[f].rlc && hc == ft[f].rhc);
          if (!rst) kill = 1'b1;
          act  = hc >= HB && hc < HB + HA && lc >= VB && lc < VB + VA;
          x    = 10'(hc - HB);
          y    = 10'(lc - VB);
          px   = act ? {y[3:0], x[3:0]} : 8'hA5;
          push = act && ft[f].ls != 0 && !kill;
          if (push) npush++;
          step(hs, vs, rst, px, push, {x, y, px});
          if (lc == 0 && hc == 7)
            check_eq("lock_start", 40'(locked), 40'(ft[f].ls));
          if (lc == 7 && hc == 0)
            check_eq("lock_end", 40'(locked), 40'(ft[f].le));
          if (ft[f].sline >= 0 && lc == ft[f].sline + 1 && hc == 2)
            check_eq("err_edge", 40'({timing_err, locked}), 40'd2);
        end
      end
      check_eq("nerr", 40'(nerr), 40'(ft[f].errs));
      check_eq("npix", 40'(npix), 40'(npush));
    end
    repeat (4) step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 28'd0);
    check_eq("drain", 40'(q.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_BACK, default 48: clocks from first high hsync_in sample to first active pixel sample.
REQ-003 SHALL have parameter H_TOTAL, default 800: clocks per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-005 SHALL have parameter V_BACK, default 33: hsync rising edges from vsync rising edge to first active line.
REQ-006 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-007 SHALL have port clock, input, 1: pixel clock, 25 MHz, same domain as source; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-low.
REQ-009 SHALL have port hsync_in, input, 1: horizontal sync, active-low pulse.
REQ-010 SHALL have port vsync_in, input, 1: vertical sync, active-low pulse.
REQ-011 SHALL have port pixel_in, input, 8: grayscale pixel sample.
REQ-012 SHALL have port pix_valid, output, 1: pix_data/pix_x/pix_y hold an active pixel this cycle.
REQ-013 SHALL have port pix_data, output, 8: captured pixel.
REQ-014 SHALL have port pix_x, output, 10: column 0..H_ACTIVE-1.
REQ-015 SHALL have port pix_y, output, 10: row 0..V_ACTIVE-1.
REQ-016 SHALL have port frame_start, output, 1: one-cycle pulse coincident with pixel (0,0).
REQ-017 SHALL have port line_done, output, 1: one-cycle pulse coincident with pixel (H_ACTIVE-1, y).
REQ-018 SHALL have port locked, output, 1: timing verified; pixels are being delivered.
REQ-019 SHALL have port timing_err, output, 1: one-cycle pulse on a line-length or frame-length mismatch while in TRAIN or LOCKED.

Function
REQ-020 SHALL register hsync_in, vsync_in and pixel_in once (stage 1); all detection uses stage-1 values.
REQ-021 SHALL detect hs_rise and vs_rise as stage-1 0->1 transitions.
REQ-022 SHALL keep h_cnt (10 bit): 0 in the cycle after hs_rise, +1 per clock, saturate at 1023.
REQ-023 SHALL keep line counter v_cnt (10 bit): 0 on vs_rise, +1 on each hs_rise otherwise, saturate at 1023.
REQ-024 On coincident vs_rise and hs_rise, vs_rise SHALL win for v_cnt, and the frame-length check SHALL use v_cnt+1.
REQ-025 SHALL implement states IDLE, TRAIN and LOCKED.
REQ-026 IDLE SHALL go to TRAIN on the first vs_rise.
REQ-027 In TRAIN or LOCKED, each hs_rise SHALL check h_cnt == H_TOTAL-1, except the first hs_rise after entering TRAIN.
REQ-028 In TRAIN or LOCKED, each vs_rise SHALL check line count == V_TOTAL.
REQ-029 TRAIN SHALL go to LOCKED on a vs_rise with all checks passing since entering TRAIN.
REQ-030 Any failed check SHALL pulse timing_err, go to IDLE and drop locked the next cycle.
REQ-031 A stage-1 sample SHALL be active when h_cnt is in [H_BACK-1, H_BACK+H_ACTIVE-2] and v_cnt is in [V_BACK, V_BACK+V_ACTIVE-1].
REQ-032 Given REQ-031, the pixel on the wire H_BACK clocks after hsync_in first samples high SHALL be x=0.
REQ-033 An active sample SHALL appear on the outputs 2 clocks after pixel_in, with pix_x = h_cnt-(H_BACK-1) and pix_y = v_cnt-V_BACK.
REQ-034 pix_valid, frame_start and line_done SHALL assert only while locked.
REQ-035 pix_data, pix_x and pix_y SHALL hold their last values when pix_valid is low.
REQ-036 pix_valid SHALL be high for exactly H_ACTIVE*V_ACTIVE cycles per locked frame.

Reset
REQ-037 While reset is low at a clock edge: state=IDLE; locked, pix_valid, frame_start, line_done and timing_err = 0; pix_data, pix_x, pix_y, h_cnt, v_cnt = 0; stage-1 hsync/vsync = 1.
REQ-038 Reset mid-frame SHALL abort capture immediately; relock SHALL need a full TRAIN frame after the next vs_rise.

Verification
REQ-039 Nominal timing generator (800x525, 48/33 back porch, ramp pixel = x[7:0]) -> locked rises at start of frame 2; frame 2 yields 307200 pix_valid cycles, first (0,0,0), last (639,479,127).
REQ-040 Locked, one line shortened to 799 clocks -> timing_err pulses once at that line's closing hs_rise; locked=0 next cycle; relock one frame after the next vs_rise.
REQ-041 Locked, one frame with 524 lines -> timing_err at vs_rise, state IDLE, no pix_valid until relock.
REQ-042 vsync rising coincident with hsync rising, otherwise nominal -> no timing_err, lock achieved.
REQ-043 Reset asserted at pixel (320,240) of a locked frame -> all outputs 0 next cycle; after release, locked returns after exactly one full TRAIN frame.
REQ-044 After lock, line_done pulses 480 times per frame, each with pix_x=639; frame_start pulses once per frame with pix_x=pix_y=0.
